// File: rtl/fg_sram_arbiter_pkg.sv
// Shared constants, bus-state encoding and address helpers for the
// foreground SRAM arbiter.
package fg_sram_arbiter_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 16;
  localparam int WR_W      = FB_ADDR_W + PIX_W;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_READ,
    BUS_TURN,
    BUS_WRITE
  } bus_state_e;

  typedef struct packed {
    logic             skip;
    logic [PIX_W-1:0] pix;
  } rd_slot_t;

  localparam rd_slot_t SLOT_SKIP = '{skip: 1'b1, pix: '0};

  function automatic logic fb_in_range(
    input logic [10:0] x,
    input logic [10:0] y
  );
    return !x[10] && !y[10] &&
           (x < 11'(FB_WIDTH)) && (y < 11'(FB_HEIGHT));
  endfunction

  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic [10:0] x,
    input logic [10:0] y
  );
    return FB_ADDR_W'(y) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fg_sram_arbiter_sync_fifo.sv
// Single-clock FIFO with async reset, full/empty flags and
// simultaneous push/pop (push accepted when full if popping).
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push)
      wptr_d = (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
    if (do_pop)
      rptr_d = (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
    if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM arbiter: fixed-latency pixel reads with priority,
// writes fill idle slots. Optional steal guard: FG_SRAM_ARB_STEAL_EN.
module fg_sram_arbiter
  import fg_sram_arbiter_pkg::*;
#(
  parameter int FETCH_DELAY   = 4,
  parameter int WR_FIFO_DEPTH = 8,
  parameter int STARVE_LIMIT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [10:0]          req_x,
  input  logic [10:0]          req_y,
  input  logic                 req_active,
  output logic [PIX_W-1:0]     fg_pixel,
  output logic                 fg_pixel_skip,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]     wr_data,
  output logic [FB_ADDR_W-1:0] sram_addr,
  output logic [PIX_W-1:0]     sram_data_out,
  input  logic [PIX_W-1:0]     sram_data_in,
  output logic                 sram_data_oe,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [15:0]          stat_steal_count
);

  localparam int PD = FETCH_DELAY - 2;

  logic                 s1_vld_q, s1_vld_d;
  logic [FB_ADDR_W-1:0] s1_addr_q, s1_addr_d;
  bus_state_e           bus_q, bus_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]     dout_q, dout_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 doe_q, doe_d;
  rd_slot_t             pipe_q [PD];
  rd_slot_t             pipe_d [PD];
  rd_slot_t             out_q, out_d;

  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [WR_W-1:0]      fifo_head;
  logic                 steal_q;

  assign wr_ready      = !fifo_full && !rst;
  assign fifo_push     = wr_valid && wr_ready;
  assign fg_pixel      = out_q.pix;
  assign fg_pixel_skip = out_q.skip;
  assign sram_addr     = addr_q;
  assign sram_data_out = dout_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_data_oe  = doe_q;

  sync_fifo #(
    .WIDTH (WR_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // first stage: range check and linear address
  always_comb begin
    s1_vld_d  = req_active && fb_in_range(req_x, req_y);
    s1_addr_d = s1_vld_d ? fb_addr(req_x, req_y) : '0;
  end

  // slot decision: read first, write only after a non-read slot
  always_comb begin
    bus_d    = BUS_IDLE;
    fifo_pop = 1'b0;
    addr_d   = addr_q;
    dout_d   = dout_q;
    if (s1_vld_q && !steal_q) begin
      bus_d  = BUS_READ;
      addr_d = s1_addr_q;
    end else if (!fifo_empty && bus_q != BUS_READ) begin
      bus_d    = BUS_WRITE;
      fifo_pop = 1'b1;
      addr_d   = fifo_head[WR_W-1:PIX_W];
      dout_d   = fifo_head[PIX_W-1:0];
    end else if (!fifo_empty) begin
      bus_d = BUS_TURN;
    end
    oe_n_d = (bus_d != BUS_READ);
    we_n_d = (bus_d != BUS_WRITE);
    doe_d  = (bus_d == BUS_WRITE);
  end

  // read capture and fixed-latency delay line
  always_comb begin
    pipe_d[0] = SLOT_SKIP;
    if (bus_q == BUS_READ)
      pipe_d[0] = '{skip: 1'b0, pix: sram_data_in};
    for (int i = 1; i < PD; i++)
      pipe_d[i] = pipe_q[i-1];
    out_d = pipe_q[PD-1];
  end

  // request, bus and read pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      bus_q     <= BUS_IDLE;
      addr_q    <= '0;
      dout_q    <= '0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
      for (int i = 0; i < PD; i++)
        pipe_q[i] <= SLOT_SKIP;
      out_q     <= SLOT_SKIP;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      bus_q     <= bus_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      doe_q     <= doe_d;
      for (int i = 0; i < PD; i++)
        pipe_q[i] <= pipe_d[i];
      out_q     <= out_d;
    end
  end

`ifdef FG_SRAM_ARB_STEAL_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          steal_d;
  logic [15:0]   steals_q, steals_d;

  // starvation count, steal flag and steal statistic
  always_comb begin
    starve_d = starve_q;
    steal_d  = steal_q;
    steals_d = steals_q;
    if (!fifo_full || bus_d == BUS_WRITE)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
    if (steal_q && bus_d == BUS_WRITE) begin
      steal_d = 1'b0;
      if (steals_q != '1)
        steals_d = steals_q + 1'b1;
    end else if (starve_q == SW'(STARVE_LIMIT)) begin
      steal_d = 1'b1;
    end
  end

  // steal guard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      steal_q  <= 1'b0;
      steals_q <= '0;
    end else begin
      starve_q <= starve_d;
      steal_q  <= steal_d;
      steals_q <= steals_d;
    end
  end

  assign stat_steal_count = steals_q;
`else
  assign steal_q          = 1'b0;
  assign stat_steal_count = '0;
`endif

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Self-checking bench for fg_sram_arbiter: SRAM model, pixel
// scoreboard from frame coordinates, directed and random phases.
module tb_fg_sram_arbiter;

  localparam int FD    = 4;
  localparam int DEPTH = 8;
  localparam int LIMIT = 64;

  typedef struct packed {
    logic        skip;
    logic [15:0] pix;
  } exp_t;

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] req_x = '0;
  logic [10:0] req_y = '0;
  logic        req_active = 1'b0;
  logic [15:0] fg_pixel;
  logic        fg_pixel_skip;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [18:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [18:0] sram_addr;
  logic [15:0] sram_data_out;
  logic [15:0] sram_data_in;
  logic        sram_data_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] stat_steal_count;

  logic [15:0] mem [0:524287];

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  wr_t  wr_pend[$];
  wr_t  acc_q[$];
  bit   prev_oe_low = 1'b0;
  bit   steal_ok = 1'b0;
  int   drops = 0;
  int   oe_lows = 0;
  int   we_lows = 0;
  int   phase_acc = 0;
  int   pacc_s = 0;
  logic rdy_s;
  logic [18:0] bus_addr_s;
  logic oe_s;
  int   widx = 0;

  fg_sram_arbiter #(
    .FETCH_DELAY   (FD),
    .WR_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_x            (req_x),
    .req_y            (req_y),
    .req_active       (req_active),
    .fg_pixel         (fg_pixel),
    .fg_pixel_skip    (fg_pixel_skip),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .sram_addr        (sram_addr),
    .sram_data_out    (sram_data_out),
    .sram_data_in     (sram_data_in),
    .sram_data_oe     (sram_data_oe),
    .sram_oe_n        (sram_oe_n),
    .sram_we_n        (sram_we_n),
    .stat_steal_count (stat_steal_count)
  );

  always #5 clk = ~clk;

  assign sram_data_in = !sram_oe_n ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_we_n)
      mem[sram_addr] <= sram_data_out;
  end

  function automatic logic [15:0] ref_pix(input int a);
    int v;
    if (a == 1285)
      return 16'hABCD;
    v = (a * 40503 + 4660) >>> 3;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic prime();
    exp_t e;
    e.skip = 1'b1;
    e.pix  = '0;
    exp_q.delete();
    for (int i = 0; i < FD + 1; i++)
      exp_q.push_back(e);
    prev_oe_low = 1'b0;
  endtask

  task automatic add_wr();
    wr_t w;
    w.a = 19'(32'h60000 + widx);
    w.d = 16'($urandom);
    widx++;
    wr_pend.push_back(w);
  endtask

  // one clock: check last edge's outputs, then drive the next request
  task automatic cyc(input bit act, input int x, input int y);
    exp_t e;
    bit   inr;
    @(negedge clk);
    e = exp_q.pop_front();
    if (steal_ok && fg_pixel_skip === 1'b1 && e.skip == 1'b0)
      drops++;
    else
      chk("pixel", 32'({fg_pixel_skip, fg_pixel}), 32'(e));
    chk("rd_then_wr", 32'(prev_oe_low && !sram_we_n), 32'd0);
    chk("oe_vs_we", 32'(sram_data_oe), 32'(!sram_we_n));
    prev_oe_low = !sram_oe_n;
    if (!sram_oe_n) oe_lows++;
    if (!sram_we_n) we_lows++;
    bus_addr_s = sram_addr;
    oe_s       = sram_oe_n;
    rdy_s      = wr_ready;
    pacc_s     = phase_acc;
    req_active = act;
    req_x      = 11'(x);
    req_y      = 11'(y);
    inr    = act && x >= 0 && x < 640 && y >= 0 && y < 480;
    e.skip = !inr;
    e.pix  = inr ? ref_pix(y * 640 + x) : 16'h0;
    exp_q.push_back(e);
    if (wr_pend.size() > 0) begin
      wr_valid = 1'b1;
      wr_addr  = wr_pend[0].a;
      wr_data  = wr_pend[0].d;
      if (wr_ready) begin
        acc_q.push_back(wr_pend.pop_front());
        phase_acc++;
      end
    end else begin
      wr_valid = 1'b0;
    end
  endtask

  task automatic rd_rand();
    cyc(1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && wr_pend.size() > 0; i++)
      cyc(1'b0, 0, 0);
    repeat (DEPTH + 6) cyc(1'b0, 0, 0);
    chk("drain", 32'(wr_pend.size()), 32'd0);
  endtask

  task automatic clr();
    oe_lows   = 0;
    we_lows   = 0;
    drops     = 0;
    phase_acc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    for (int a = 0; a < 524288; a++)
      mem[a] = ref_pix(a);

    // reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_pix", 32'(fg_pixel), 32'd0);
    chk("rst_skip", 32'(fg_pixel_skip), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dout", 32'(sram_data_out), 32'd0);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_doe", 32'(sram_data_oe), 32'd0);
    chk("rst_stat", 32'(stat_steal_count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prime();

    // single read of (5,2)
    cyc(1'b1, 5, 2);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);
    chk("single_addr", 32'(bus_addr_s), 32'd1285);
    chk("single_oe_n", 32'(oe_s), 32'd0);
    repeat (FD + 1) cyc(1'b0, 0, 0);

    // out-of-range and inactive
    clr();
    cyc(1'b1, -1, 0);
    cyc(1'b1, 640, 0);
    cyc(1'b1, 0, 480);
    cyc(1'b0, 5, 5);
    repeat (FD + 2) cyc(1'b0, 0, 0);
    chk("oor_no_oe", 32'(oe_lows), 32'd0);

    // isolated gap, then a double gap for the write
    clr();
    repeat (3) rd_rand();
    add_wr();
    w = wr_pend[0];
    repeat (3) rd_rand();
    cyc(1'b0, 0, 0);
    repeat (4) rd_rand();
    chk("gap1_no_write", 32'(we_lows), 32'd0);
    repeat (5) cyc(1'b0, 0, 0);
    chk("gap2_one_write", 32'(we_lows), 32'd1);
    chk("gap2_mem", 32'(mem[w.a]), 32'(w.d));

`ifdef FG_SRAM_ARB_STEAL_EN
    // steal under continuous reads
    clr();
    steal_ok = 1'b1;
    repeat (5) rd_rand();
    repeat (DEPTH) add_wr();
    repeat (110) rd_rand();
    chk("steal_writes", 32'(we_lows), 32'd1);
    chk("steal_drops_le2", 32'(drops <= 2), 32'd1);
    chk("steal_count", 32'(stat_steal_count), 32'd1);
    chk("steal_ready", 32'(rdy_s), 32'd1);
    repeat (FD + 1) cyc(1'b0, 0, 0);
    steal_ok = 1'b0;
    drain();
`else
    // read saturation starves writes
    clr();
    for (int i = 0; i < 200; i++) begin
      if (i == 5)
        repeat (DEPTH + 1) add_wr();
      rd_rand();
      chk("sat_ready", 32'(rdy_s), 32'(pacc_s < DEPTH));
    end
    chk("sat_no_write", 32'(we_lows), 32'd0);
    chk("sat_accepted", 32'(phase_acc), 32'(DEPTH));
    drain();
    chk("stat_zero", 32'(stat_steal_count), 32'd0);
`endif

    // random mix of reads and writes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        add_wr();
      cyc($urandom_range(0, 3) != 0,
          int'($urandom_range(0, 679)) - 20,
          int'($urandom_range(0, 519)) - 20);
    end
    drain();
    foreach (acc_q[i])
      chk("mem_write", 32'(mem[acc_q[i].a]), 32'(acc_q[i].d));

    // reset during a read burst
    repeat (FD) rd_rand();
    #2 rst = 1'b1;
    req_active = 1'b0;
    wr_valid   = 1'b0;
    #1;
    chk("mid_rst_pix", 32'(fg_pixel), 32'd0);
    chk("mid_rst_skip", 32'(fg_pixel_skip), 32'd1);
    chk("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prime();
    repeat (FD) rd_rand();
    repeat (FD + 2) cyc(1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
